// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses a combinational instruction
// memory and holds the returned word in a one-entry valid/ready stage for decode.
module imem_fetch_ctrl #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic            busy,
    output logic            fault,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] COUNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO_WORD = {XLEN{1'b0}};

    logic [1:0]      state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] inst_r, inst_s;
    logic [XLEN-1:0] inst_pc_r, inst_pc_s;
    logic [XLEN-1:0] fetch_count_r, fetch_count_s;
    logic            inst_valid_r, inst_valid_s;
    logic            fault_r, fault_s;
    logic            busy_r;
    logic            redir_s;
    logic            fire_s;

    // Next-state: redirect outranks halt, halt outranks start, start outranks fetch.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        inst_s        = inst_r;
        inst_pc_s     = inst_pc_r;
        inst_valid_s  = inst_valid_r;
        fault_s       = fault_r;
        fetch_count_s = fetch_count_r;
        fire_s        = 1'b0;
        redir_s       = redir_valid && (state_r != ST_FAULT);

        if (redir_s) begin
            pc_s         = redir_pc;
            inst_valid_s = 1'b0;
            if (redir_pc[1:0] != 2'b00) begin
                fault_s = 1'b1;
                state_s = ST_FAULT;
            end else begin
                fault_s = fault_r;
                state_s = state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start && !halt_req) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_s = ST_HALT;
                    end else if (!inst_valid_r || inst_ready) begin
                        fire_s = 1'b1;
                    end else begin
                        fire_s = 1'b0;
                    end
                end
                ST_FAULT: state_s = ST_FAULT;
                default:  state_s = ST_IDLE;
            endcase

            // A fetch refills the stage; otherwise an accepted word just drains it.
            if (fire_s) begin
                inst_s        = imem_rdata;
                inst_pc_s     = pc_r;
                inst_valid_s  = 1'b1;
                pc_s          = pc_r + PC_STEP;
                fetch_count_s = fetch_count_r + COUNT_ONE;
            end else if (inst_valid_r && inst_ready) begin
                inst_valid_s = 1'b0;
            end else begin
                inst_valid_s = inst_valid_r;
            end
        end
    end

    // State and output registers; busy is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            inst_r        <= ZERO_WORD;
            inst_pc_r     <= ZERO_WORD;
            inst_valid_r  <= 1'b0;
            fault_r       <= 1'b0;
            fetch_count_r <= ZERO_WORD;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            inst_r        <= inst_s;
            inst_pc_r     <= inst_pc_s;
            inst_valid_r  <= inst_valid_s;
            fault_r       <= fault_s;
            fetch_count_r <= fetch_count_s;
            busy_r        <= (state_s == ST_RUN);
        end
    end

    assign imem_addr   = pc_r;
    assign inst        = inst_r;
    assign inst_pc     = inst_pc_r;
    assign inst_valid  = inst_valid_r;
    assign busy        = busy_r;
    assign fault       = fault_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboarded bench for imem_fetch_ctrl: a behavioural model pushes the expected
// outputs per clock, a monitor pops and compares; plus a wrap-around instance.
module tb_imem_fetch_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt_req, redir_valid, inst_ready;
    logic [31:0] redir_pc, imem_addr, imem_rdata, inst, inst_pc, fetch_count;
    logic        inst_valid, busy, fault;

    logic        w_start;
    logic [31:0] w_addr, w_inst, w_inst_pc, w_count;
    logic        w_valid, w_busy, w_fault;

    always #5 clk = ~clk;

    logic [31:0] prog [0:4] = '{32'hFFC4A303, 32'h00832383, 32'h0064A423,
                                32'h00B62423, 32'h0062E233};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h14) return prog[a[4:2]];
        return a ^ 32'h5A5A0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    imem_fetch_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .busy(busy),
        .fault(fault), .fetch_count(fetch_count)
    );

    imem_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFFFFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start), .halt_req(1'b0),
        .redir_valid(1'b0), .redir_pc(32'h0), .imem_addr(w_addr),
        .imem_rdata(32'h00000013), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_valid(w_valid), .inst_ready(1'b1), .busy(w_busy),
        .fault(w_fault), .fetch_count(w_count)
    );

    typedef struct {
        logic [31:0] addr, inst, ipc, cnt;
        logic        v, busy, fault;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    int          m_mode;
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
    logic        m_v, m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
        m_cnt = 32'h0; m_v = 1'b0; m_fault = 1'b0;
    endtask

    // One clock of the fetch unit as described: redirect, then halt, start, fetch, drain.
    task automatic model_step(input logic st, input logic hl, input logic rv,
                              input logic [31:0] rp, input logic rd);
        logic fetched = 1'b0;
        if (m_mode != M_FAULT && rv) begin
            m_pc = rp;
            m_v  = 1'b0;
            if (rp % 4 != 0) begin
                m_mode  = M_FAULT;
                m_fault = 1'b1;
            end
        end else begin
            if (m_mode == M_RUN && hl) m_mode = M_HALT;
            else if ((m_mode == M_IDLE || m_mode == M_HALT) && st && !hl) m_mode = M_RUN;
            else if (m_mode == M_RUN && (!m_v || rd)) begin
                m_inst  = mem_word(m_pc);
                m_ipc   = m_pc;
                m_v     = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_cnt   = m_cnt + 32'd1;
                fetched = 1'b1;
            end
            if (!fetched && m_v && rd) m_v = 1'b0;
        end
        q.push_back('{m_pc, m_inst, m_ipc, m_cnt, m_v, (m_mode == M_RUN), m_fault});
    endtask

    // Monitor: compare every registered output against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("imem_addr",   imem_addr,   e.addr);
            chk("inst",        inst,        e.inst);
            chk("inst_pc",     inst_pc,     e.ipc);
            chk("inst_valid",  {31'b0, inst_valid}, {31'b0, e.v});
            chk("busy",        {31'b0, busy},       {31'b0, e.busy});
            chk("fault",       {31'b0, fault},      {31'b0, e.fault});
            chk("fetch_count", fetch_count, e.cnt);
        end
    end

    // Drive one cycle of stimulus from a negedge, returning at the next negedge.
    task automatic cyc(input logic st, input logic hl, input logic rv,
                       input logic [31:0] rp, input logic rd);
        start = st; halt_req = hl; redir_valid = rv; redir_pc = rp; inst_ready = rd;
        @(posedge clk);
        model_step(st, hl, rv, rp, rd);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle and checked before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_imem_addr",  imem_addr,   32'h0);
        chk("rst_fault",      {31'b0, fault}, 32'h0);
        chk("rst_count",      fetch_count, 32'h0);
        chk("rst_w_valid",    {31'b0, w_valid}, 32'h0);
        chk("rst_w_addr",     w_addr, 32'hFFFFFFFC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;
        redir_pc = 32'h0; inst_ready = 1'b0; w_start = 1'b0;
        model_reset();
        #12;
        chk("init_inst",    inst, 32'h0);
        chk("init_inst_pc", inst_pc, 32'h0);
        chk("init_busy",    {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch of the program image.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s1_inst",  inst, 32'h0062E233);
        chk("s1_pc",    inst_pc, 32'h10);
        chk("s1_count", fetch_count, 32'd5);
        chk("s1_busy",  {31'b0, busy}, 32'h1);

        // Back-pressure holds word1 and the PC.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("s2_inst",  inst, 32'h00832383);
        chk("s2_addr",  imem_addr, 32'h08);
        chk("s2_count", fetch_count, 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s2_next",  inst, 32'h0064A423);

        // Aligned redirect flushes, then fetches from the target.
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        chk("s3_flush", {31'b0, inst_valid}, 32'h0);
        chk("s3_addr",  imem_addr, 32'h10);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s3_inst",  inst, 32'h0062E233);
        chk("s3_pc",    inst_pc, 32'h10);

        // Misaligned redirect is terminal until reset.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000000A, 1'b1);
        chk("s4_fault", {31'b0, fault}, 32'h1);
        chk("s4_busy",  {31'b0, busy}, 32'h0);
        chk("s4_addr",  imem_addr, 32'h0A);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s4_count", fetch_count, 32'd4);

        // Redirect beats halt; a later halt freezes fetching but keeps the pending word.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h08, 1'b1);
        chk("s5_busy",  {31'b0, busy}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s5_inst",  inst, 32'h0064A423);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("s5_held",  {31'b0, inst_valid}, 32'h1);
        chk("s5_count", fetch_count, 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s5_drain", {31'b0, inst_valid}, 32'h0);

        // PC wrap on the high-reset-PC instance, then an asynchronous reset mid-run.
        w_start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        w_start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s6_pc_hi", w_inst_pc, 32'hFFFFFFFC);
        chk("s6_inst",  w_inst, 32'h00000013);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s6_pc_wrap", w_inst_pc, 32'h0);
        chk("s6_addr",    w_addr, 32'h4);
        do_reset();

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            for (int n = 0; n < 300; n++) begin
                logic [31:0] rp;
                if ($urandom_range(0, 7) == 0) rp = $urandom;
                else rp = 32'($urandom_range(0, 7)) * 32'd4;
                cyc($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 9) == 0, rp, $urandom_range(0, 2) != 0);
            end
            do_reset();
        end

        @(negedge clk);
        chk("sb_drain", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
